// File: rtl/encoder_pkg.sv
// Shared types and helpers for the 16-to-4 encoder.
//   ENC_IN_W / ENC_OUT_W : request-vector and index widths
//   enc_vec_t / enc_idx_t: request vector and binary index types
//   idx_bit_mask(k)      : request positions whose index has bit k set
package encoder_pkg;

    localparam int unsigned ENC_IN_W  = 16;
    localparam int unsigned ENC_OUT_W = 4;

    typedef logic [ENC_IN_W-1:0]  enc_vec_t;
    typedef logic [ENC_OUT_W-1:0] enc_idx_t;

    // Mask of input positions i where bit k of i is 1; ORing the masked
    // request gives bit k of the index for a one-hot input.
    function automatic enc_vec_t idx_bit_mask(input int unsigned k);
        enc_vec_t m;
        m = '0;
        for (int unsigned i = 0; i < ENC_IN_W; i++) begin
            m[i] = (((i >> k) & 32'd1) != 32'd0);
        end
        return m;
    endfunction

endpackage

// File: rtl/encoder_16x4_core.sv
// Combinational core of the 16-to-4 encoder.
//   in    : request vector
//   idx   : index of the selected set bit (0 when in is zero)
//   any   : at least one bit of in is set
//   multi : two or more bits of in are set
//   PRIO_MSB selects highest (1) or lowest (0) set bit on multi-hot input.
module encoder_16x4_core
    import encoder_pkg::*;
#(
    parameter bit PRIO_MSB = 1'b1
) (
    input  logic [ENC_IN_W-1:0]  in,
    output logic [ENC_OUT_W-1:0] idx,
    output logic                 any,
    output logic                 multi
);

    enc_idx_t onehot_idx;
    enc_idx_t prio_idx;
    logic     seen;
    logic     multi_hot;

    // One-hot encode: each index bit is an OR over a fixed set of inputs.
    always_comb begin
        onehot_idx = '0;
        for (int unsigned k = 0; k < ENC_OUT_W; k++) begin
            onehot_idx[k] = |(in & idx_bit_mask(k));
        end
    end

    // Priority select; the last match in scan order wins.
    always_comb begin
        prio_idx = '0;
        if (PRIO_MSB) begin
            for (int unsigned i = 0; i < ENC_IN_W; i++) begin
                if (in[i]) prio_idx = ENC_OUT_W'(i);
            end
        end else begin
            for (int i = int'(ENC_IN_W) - 1; i >= 0; i--) begin
                if (in[i]) prio_idx = ENC_OUT_W'(i);
            end
        end
    end

    // At-least-two detect: a set bit seen after an earlier set bit.
    always_comb begin
        seen      = 1'b0;
        multi_hot = 1'b0;
        for (int unsigned i = 0; i < ENC_IN_W; i++) begin
            multi_hot = multi_hot | (seen & in[i]);
            seen      = seen | in[i];
        end
    end

    assign any   = |in;
    assign multi = multi_hot;
    // The OR encoder is exact for one-hot and zero inputs; priority only
    // matters once more than one bit is set.
    assign idx   = multi_hot ? prio_idx : onehot_idx;

endmodule

// File: rtl/encoder_16x4.sv
// Registered 16-to-4 binary encoder.
//   clk   : rising-edge clock
//   rst   : asynchronous active-high reset
//   en    : capture enable; outputs hold when low
//   in    : one-hot request vector
//   out   : registered index of the selected set bit
//   valid : registered, captured input had any bit set
//   multi : registered, captured input had two or more bits set
module encoder_16x4
    import encoder_pkg::*;
#(
    parameter bit PRIO_MSB = 1'b1,
    localparam int unsigned IN_W  = ENC_IN_W,
    localparam int unsigned OUT_W = ENC_OUT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [IN_W-1:0]  in,
    output logic [OUT_W-1:0] out,
    output logic             valid,
    output logic             multi
);

    enc_idx_t idx_c;
    logic     any_c;
    logic     multi_c;

    encoder_16x4_core #(
        .PRIO_MSB (PRIO_MSB)
    ) u_core (
        .in    (in),
        .idx   (idx_c),
        .any   (any_c),
        .multi (multi_c)
    );

    // Output registers; reset wins over enable.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out   <= '0;
            valid <= 1'b0;
            multi <= 1'b0;
        end else if (en) begin
            out   <= idx_c;
            valid <= any_c;
            multi <= multi_c;
        end
    end

endmodule

// File: tb/tb_encoder_16x4.sv
// Self-checking bench for encoder_16x4: both priority modes side by side,
// directed cases with literal expectations plus randomized traffic
// checked against a behavioural model every cycle.
module tb_encoder_16x4;

    logic        clk;
    logic        rst;
    logic        en;
    logic [15:0] in;
    logic [3:0]  out_msb, out_lsb;
    logic        valid_msb, valid_lsb;
    logic        multi_msb, multi_lsb;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    // Model state (what the outputs must currently show)
    logic [3:0] m_out_msb, m_out_lsb;
    logic       m_valid, m_multi;

    encoder_16x4 #(.PRIO_MSB(1'b1)) u_msb (
        .clk(clk), .rst(rst), .en(en), .in(in),
        .out(out_msb), .valid(valid_msb), .multi(multi_msb)
    );

    encoder_16x4 #(.PRIO_MSB(1'b0)) u_lsb (
        .clk(clk), .rst(rst), .en(en), .in(in),
        .out(out_lsb), .valid(valid_lsb), .multi(multi_lsb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Index of highest or lowest set bit; 0 for an empty vector.
    function automatic logic [3:0] ref_idx(input logic [15:0] v, input bit msb);
        logic [3:0] r;
        r = 4'd0;
        if (msb) begin
            for (int i = 15; i >= 0; i--) begin
                if (v[i]) begin r = 4'(i); break; end
            end
        end else begin
            for (int i = 0; i < 16; i++) begin
                if (v[i]) begin r = 4'(i); break; end
            end
        end
        return r;
    endfunction

    // Behavioural model of the captured state
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_out_msb <= 4'd0;
            m_out_lsb <= 4'd0;
            m_valid   <= 1'b0;
            m_multi   <= 1'b0;
        end else if (en) begin
            m_out_msb <= ref_idx(in, 1'b1);
            m_out_lsb <= ref_idx(in, 1'b0);
            m_valid   <= ($countones(in) >= 1);
            m_multi   <= ($countones(in) >= 2);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Per-cycle compare against the model, away from the active edge
    bit cmp_on = 1'b0;
    always @(negedge clk) begin
        if (cmp_on) begin
            chk("cyc_out_msb",   32'(out_msb),   32'(m_out_msb));
            chk("cyc_out_lsb",   32'(out_lsb),   32'(m_out_lsb));
            chk("cyc_valid_msb", 32'(valid_msb), 32'(m_valid));
            chk("cyc_valid_lsb", 32'(valid_lsb), 32'(m_valid));
            chk("cyc_multi_msb", 32'(multi_msb), 32'(m_multi));
            chk("cyc_multi_lsb", 32'(multi_lsb), 32'(m_multi));
        end
    end

    // Drive inputs, let the next rising edge capture them, settle 1 time unit.
    task automatic apply(input logic [15:0] v, input logic e);
        in = v;
        en = e;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_all(input string name, input logic [3:0] o_msb,
                              input logic [3:0] o_lsb, input logic v, input logic m);
        chk({name, "_out_msb"}, 32'(out_msb),   32'(o_msb));
        chk({name, "_out_lsb"}, 32'(out_lsb),   32'(o_lsb));
        chk({name, "_valid"},   32'(valid_msb), 32'(v));
        chk({name, "_multi"},   32'(multi_msb), 32'(m));
    endtask

    logic [15:0] r;

    initial begin
        rst = 1'b1;
        en  = 1'b0;
        in  = 16'h0000;
        #1;
        expect_all("reset", 4'd0, 4'd0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        cmp_on = 1'b1;
        rst = 1'b0;

        // One-hot sweep
        for (int i = 0; i < 16; i++) begin
            apply(16'h0001 << i, 1'b1);
            expect_all("onehot", 4'(i), 4'(i), 1'b1, 1'b0);
        end

        // Zero, then index 0
        apply(16'h0000, 1'b1);
        expect_all("zero", 4'd0, 4'd0, 1'b0, 1'b0);
        apply(16'h0001, 1'b1);
        expect_all("bit0", 4'd0, 4'd0, 1'b1, 1'b0);

        // Multi-hot, both priorities
        apply(16'h8001, 1'b1);
        expect_all("mh_8001", 4'd15, 4'd0, 1'b1, 1'b1);
        apply(16'h0030, 1'b1);
        expect_all("mh_0030", 4'd5, 4'd4, 1'b1, 1'b1);
        apply(16'hFFFF, 1'b1);
        expect_all("mh_ffff", 4'd15, 4'd0, 1'b1, 1'b1);

        // Enable hold
        apply(16'h0400, 1'b1);
        expect_all("cap_0400", 4'd10, 4'd10, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            apply(16'h0002, 1'b0);
            expect_all("hold", 4'd10, 4'd10, 1'b1, 1'b0);
        end
        apply(16'h0002, 1'b1);
        expect_all("reenable", 4'd1, 4'd1, 1'b1, 1'b0);

        // Asynchronous reset between edges
        apply(16'h8000, 1'b1);
        expect_all("pre_rst", 4'd15, 4'd15, 1'b1, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        expect_all("async_rst", 4'd0, 4'd0, 1'b0, 1'b0);
        for (int i = 0; i < 2; i++) begin
            apply(16'hFFFF, 1'b1);
            expect_all("rst_held", 4'd0, 4'd0, 1'b0, 1'b0);
        end

        // Release: first edge captures
        rst = 1'b0;
        apply(16'h0100, 1'b1);
        expect_all("release", 4'd8, 4'd8, 1'b1, 1'b0);

        // Randomized traffic, checked by the per-cycle compare
        for (int n = 0; n < 400; n++) begin
            case ($urandom_range(0, 3))
                0: r = 16'h0001 << $urandom_range(0, 15);
                1: r = 16'h0000;
                2: r = (16'h0001 << $urandom_range(0, 15)) | (16'h0001 << $urandom_range(0, 15));
                default: r = 16'($urandom);
            endcase
            rst = ($urandom_range(0, 49) == 0);
            apply(r, ($urandom_range(0, 3) != 0));
        end
        rst = 1'b0;
        apply(16'h0000, 1'b1);
        @(negedge clk);
        cmp_on = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
